// File: rtl/freq_readout.sv
// Sweeps the 4-entry frequency bank, averages the entries and converts the mean to packed BCD.
// The result is offered on a valid/ready handshake and held afterwards for display persistence.
module freq_readout #(
    parameter int DATA_WIDTH     = 26,
    parameter int DIGITS         = 8,
    parameter int REFRESH_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [1:0]              addr_r,
    input  logic [DATA_WIDTH-1:0]   data_r,
    output logic [DATA_WIDTH-1:0]   avg_out,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    overflow,
    output logic                    valid,
    input  logic                    ready
);

    localparam int TW = $clog2(REFRESH_CYCLES);
    localparam int SW = DATA_WIDTH + 2;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    function automatic logic [63:0] dec_limit(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] DEC_MAX = dec_limit(DIGITS);

    // Double-dabble correction: any digit of 5 or more gets +3 before the next shift.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] saturate_bcd(input logic [BW-1:0] b, input logic ovf);
        return ovf ? {DIGITS{4'h9}} : b;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_READ, S_AVG, S_CONV, S_OUT} state_t;

    state_t                  state_q;
    logic [TW-1:0]           timer_q;
    logic                    tick_q;
    logic                    pending_q;
    logic                    phase_q;
    logic [1:0]              addr_q;
    logic [SW-1:0]           sum_q;
    logic [DATA_WIDTH-1:0]   avg_q;
    logic [DATA_WIDTH-1:0]   bin_q;
    logic [BW-1:0]           dab_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   avg_out_q;
    logic [BW-1:0]           bcd_out_q;
    logic                    ovf_out_q;
    logic                    valid_q;

    logic [BW-1:0]           dab_adj_d;
    logic                    ovf_d;
    logic                    timer_wrap_d;

    assign dab_adj_d    = add3_digits(dab_q);
    assign ovf_d        = ({{(64-DATA_WIDTH){1'b0}}, avg_q} > DEC_MAX);
    assign timer_wrap_d = (timer_q == TW'(REFRESH_CYCLES - 1));

    // Timer runs independently of the FSM so the sweep period stays exact under continuous ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            timer_q <= timer_wrap_d ? '0 : timer_q + 1'b1;
            tick_q  <= timer_wrap_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            phase_q   <= 1'b0;
            addr_q    <= 2'd0;
            sum_q     <= '0;
            avg_q     <= '0;
            bin_q     <= '0;
            dab_q     <= '0;
            cnt_q     <= '0;
            avg_out_q <= '0;
            bcd_out_q <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (tick_q && state_q != S_IDLE) pending_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (tick_q || pending_q) begin
                        pending_q <= 1'b0;
                        sum_q     <= '0;
                        addr_q    <= 2'd0;
                        phase_q   <= 1'b0;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    // addr_q doubles as the entry index; phase B captures the entry it points at.
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        sum_q   <= sum_q + SW'(data_r);
                        phase_q <= 1'b0;
                        if (addr_q == 2'd3) state_q <= S_AVG;
                        else                addr_q  <= addr_q + 2'd1;
                    end
                end
                S_AVG: begin
                    avg_q   <= sum_q[SW-1:2];
                    bin_q   <= sum_q[SW-1:2];
                    dab_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_CONV;
                end
                S_CONV: begin
                    // DATA_WIDTH shift cycles, then one publishing cycle that enters OUT.
                    if (cnt_q == CW'(DATA_WIDTH)) begin
                        avg_out_q <= avg_q;
                        ovf_out_q <= ovf_d;
                        bcd_out_q <= saturate_bcd(dab_q, ovf_d);
                        valid_q   <= 1'b1;
                        state_q   <= S_OUT;
                    end else begin
                        dab_q <= {dab_adj_d[BW-2:0], bin_q[DATA_WIDTH-1]};
                        bin_q <= bin_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_r   = addr_q;
    assign avg_out  = avg_out_q;
    assign bcd_out  = bcd_out_q;
    assign overflow = ovf_out_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_freq_readout.sv
// Bench for freq_readout: two instances (DIGITS=8 and DIGITS=4) reading modelled banks,
// with a scoreboard of expected results popped by a negedge monitor.
`timescale 1ns/1ps
module tb_freq_readout;

    localparam int DW = 26;
    localparam int RC = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            ready;
    logic            ready2;
    logic [1:0]      addr_r, addr_r2;
    logic [DW-1:0]   data_r, data_r2, avg_out, avg_out2;
    logic [31:0]     bcd_out;
    logic [15:0]     bcd_out2;
    logic            overflow, overflow2, valid, valid2;

    logic [DW-1:0]   bank  [4];
    logic [DW-1:0]   bank2 [4];

    assign data_r  = bank[addr_r];
    assign data_r2 = bank2[addr_r2];
    assign ready2  = 1'b1;

    freq_readout #(.DATA_WIDTH(DW), .DIGITS(8), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .data_r(data_r),
        .avg_out(avg_out), .bcd_out(bcd_out), .overflow(overflow),
        .valid(valid), .ready(ready)
    );

    freq_readout #(.DATA_WIDTH(DW), .DIGITS(4), .REFRESH_CYCLES(RC)) dut4 (
        .clk(clk), .reset_n(reset_n), .addr_r(addr_r2), .data_r(data_r2),
        .avg_out(avg_out2), .bcd_out(bcd_out2), .overflow(overflow2),
        .valid(valid2), .ready(ready2)
    );

    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            cyc;
        logic [DW-1:0] avg;
        logic [31:0]   bcd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input int c, input logic [DW-1:0] a, input logic [31:0] b);
        exp_t e;
        e.cyc = c; e.avg = a; e.bcd = b;
        sb.push_back(e);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_bank(input logic [DW-1:0] a, b, c, d);
        bank[0] = a; bank[1] = b; bank[2] = c; bank[3] = d;
    endtask

    // Monitor for the DIGITS=8 instance
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] last_avg   = '0;
    logic [31:0]   last_bcd   = '0;
    logic          last_ovf   = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0; prev_ready = 1'b0;
            last_avg = '0; last_bcd = '0; last_ovf = 1'b0;
        end else begin
            if (prev_valid && prev_ready) begin
                check("valid_after_handshake", valid, 0);
                check("persist_avg", avg_out, last_avg);
                check("persist_bcd", bcd_out, last_bcd);
            end else if (prev_valid) begin
                check("stall_valid", valid, 1);
                check("stall_avg", avg_out, last_avg);
                check("stall_bcd", bcd_out, last_bcd);
                check("stall_ovf", overflow, last_ovf);
            end else if (valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_cycle", cyc, mon_e.cyc);
                    check("avg_out", avg_out, mon_e.avg);
                    check("bcd_out", bcd_out, mon_e.bcd);
                    check("overflow", overflow, 0);
                end
                last_avg = avg_out; last_bcd = bcd_out; last_ovf = overflow;
            end else begin
                check("idle_persist_avg", avg_out, last_avg);
                check("idle_persist_bcd", bcd_out, last_bcd);
            end
            prev_valid = valid;
            prev_ready = ready;
        end
    end

    // Monitor for the DIGITS=4 instance: every result must saturate
    int n_v2 = 0;
    always @(negedge clk) begin
        if (reset_n && valid2) begin
            n_v2++;
            check("d4_avg", avg_out2, 12345);
            check("d4_bcd", bcd_out2, 16'h9999);
            check("d4_ovf", overflow2, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        ready   = 1'b1;
        set_bank(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) bank2[i] = 26'd12345;

        push(137, 26'd1000,     32'h0000_1000);
        push(237, 26'd2,        32'h0000_0002);
        push(337, 26'd50000000, 32'h5000_0000);
        push(437, 26'd8,        32'h0000_0008);
        push(625, 26'd8,        32'h0000_0008);
        push(663, 26'd8,        32'h0000_0008);
        push(737, 26'd8,        32'h0000_0008);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    valid,    0);
        check("rst_avg",      avg_out,  0);
        check("rst_bcd",      bcd_out,  0);
        check("rst_ovf",      overflow, 0);
        check("rst_addr",     addr_r,   0);
        check("rst_valid_d4", valid2,   0);

        @(negedge clk);
        reset_n = 1'b1;
        set_bank(1000, 1000, 1000, 1000);

        for (int k = 0; k < 8; k++) begin
            at_cyc(101 + k);
            check("addr_seq", addr_r, k / 2);
        end
        at_cyc(136);
        check("latency_not_early", valid, 0);

        at_cyc(150); set_bank(1, 2, 3, 5);
        at_cyc(250); set_bank(50000000, 50000000, 50000000, 50000000);
        at_cyc(350); set_bank(7, 8, 9, 10);
        at_cyc(430); ready = 1'b0;
        at_cyc(587); ready = 1'b1;

        at_cyc(820);
        check("pre_reset_avg",  avg_out, 8);
        check("pre_reset_addr", addr_r,  3);
        #1 reset_n = 1'b0;
        #1;
        check("midconv_valid", valid,    0);
        check("midconv_avg",   avg_out,  0);
        check("midconv_bcd",   bcd_out,  0);
        check("midconv_addr",  addr_r,   0);
        check("midconv_ovf",   overflow, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_bank(100, 200, 300, 400);
        push(137, 26'd250, 32'h0000_0250);

        at_cyc(136);
        check("post_reset_no_early", valid, 0);
        at_cyc(140);

        check("scoreboard_drained", sb.size(), 0);
        check("d4_result_count",    n_v2,      8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_readout.md
# freq_readout

Read-side companion to the frequency measurement memory. Periodically sweeps all four entries of the 4-deep frequency register bank through its read port and averages them. Converts the average to packed BCD for the seven-segment display driver. Presents the result on a valid/ready handshake; this is the consumer between the measurement bank and the display path.

## Interface

Parameters:
- DATA_WIDTH, 26, width of one stored frequency word (`$clog2(50_000_000)`)
- DIGITS, 8, number of BCD output digits
- REFRESH_CYCLES, 50_000_000, clk cycles between readout sweeps (≥ 64)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- addr_r  out  2  read address to the frequency bank
- data_r  in  DATA_WIDTH  read data from the frequency bank; combinational on addr_r
- avg_out  out  DATA_WIDTH  truncated mean of the four entries
- bcd_out  out  4*DIGITS  packed BCD of avg_out; digit 0 in bits [3:0]
- overflow  out  1  avg_out exceeds 10^DIGITS−1; bcd_out forced to all 9s
- valid  out  1  result available
- ready  in  1  consumer accepts result

## Operation

- Refresh timer:
  - Free-running counter 0..REFRESH_CYCLES−1.
  - Registered tick is high for one cycle on wrap.
- Pending flag:
  - Set by a tick in any state other than IDLE. One-deep: further ticks while already set are dropped.
  - Cleared when IDLE consumes it.
- FSM states: IDLE, READ, AVG, CONV, OUT.
  - IDLE → READ when tick or pending. Clear sum, addr_r ← 0, index ← 0.
  - READ: two cycles per entry.
    - Phase A: addr_r holds index.
    - Phase B: sum ← sum + data_r, then index increments.
    - After index 3 is captured → AVG.
    - addr_r always registered; never glitches.
  - AVG (1 cycle):
    - avg ← sum[DATA_WIDTH+1:2]. Accumulator is DATA_WIDTH+2 bits and cannot overflow.
    - Load the double-dabble shift register.
    - → CONV.
  - CONV (exactly DATA_WIDTH cycles): shift-and-add-3 double dabble, one bit per cycle → OUT.
  - OUT:
    - avg_out, bcd_out and overflow update on entry.
    - valid = 1. Outputs are held stable while valid && !ready.
    - On an edge with valid && ready → IDLE, valid ← 0.
- After a handshake, avg_out, bcd_out and overflow keep their last values (display persistence).
- overflow = (avg > 10^DIGITS−1). When set, bcd_out = all 4'h9. Cannot occur with default parameters.
- The bank may be written at any time. Each entry is sampled at its own phase-B edge, with no coherency across entries. This is required behaviour.

## Timing

- Reset (asynchronous assert, synchronous release) values:
  - state IDLE; addr_r 0; avg_out 0; bcd_out 0; overflow 0; valid 0.
  - Timer 0; tick 0; pending 0; sum 0.
- Latency: valid rises exactly 10+DATA_WIDTH edges after the edge at which IDLE samples tick/pending (36 for default). Breakdown: 8 READ + 1 AVG + DATA_WIDTH CONV + 1 entry into OUT.
- ready may be high before valid. The handshake then completes on the first OUT cycle and valid is high for exactly one cycle.
- Tick and handshake on the same edge: pending is set; IDLE starts the next sweep on the following edge.
- reset_n low mid-sweep or mid-conversion:
  - All state returns to reset values immediately.
  - No partial result is ever presented.
  - The timer restarts from 0.
- Sweep period under continuous ready is exactly REFRESH_CYCLES cycles (the timer is independent of the FSM).

## Test plan

Bench models a 4×DATA_WIDTH combinational-read bank; REFRESH_CYCLES = 100.

- Reset, then entries {1000, 1000, 1000, 1000}, ready = 1 → valid pulses once, 36 edges after the tick. avg_out = 1000, bcd_out = 32'h00001000, overflow = 0. addr_r sequence 0,0,1,1,2,2,3,3.
- Entries {1, 2, 3, 5} → avg_out = 2 (truncated 11/4), bcd_out = 32'h00000002.
- All entries 50_000_000 → avg_out = 50_000_000, bcd_out = 32'h50000000.
- Backpressure: ready = 0 for 150 cycles → valid stays high, outputs constant, and a second tick sets pending. Raising ready completes the handshake, and the next sweep starts on the following edge, with valid again 36 edges later.
- reset_n pulsed low during CONV → valid, avg_out, bcd_out and addr_r are 0 immediately. The next result appears only after a full new sweep.
- DIGITS = 4, entries all 12_345 → overflow = 1, bcd_out = 16'h9999, avg_out = 12_345.
